// File: rtl/ctr_array_sched_if.sv
// rtl/ctr_array_sched_if.sv - lookup/update request and counter-array port bundle
// slave is the scheduler's view, master is the predictor/array environment's view.
interface ctr_array_sched_if #(
    parameter int IDX_W = 9,
    parameter int LANES = 8,
    parameter int CTR_W = 2
);
    localparam int DATA_W = LANES * CTR_W;

    logic              io_r_req_valid;
    logic              io_r_req_ready;
    logic [IDX_W-1:0]  io_r_req_idx;
    logic              io_r_resp_valid;
    logic [DATA_W-1:0] io_r_resp_data;
    logic              io_w_req_valid;
    logic              io_w_req_ready;
    logic [IDX_W-1:0]  io_w_req_idx;
    logic [LANES-1:0]  io_w_req_mask;
    logic [LANES-1:0]  io_w_req_taken;
    logic              io_init_done;
    logic              arr_W0_en;
    logic [IDX_W-1:0]  arr_W0_addr;
    logic [DATA_W-1:0] arr_W0_data;
    logic [LANES-1:0]  arr_W0_mask;
    logic              arr_R0_en;
    logic [IDX_W-1:0]  arr_R0_addr;
    logic [DATA_W-1:0] arr_R0_data;
`ifdef CTR_ARRAY_SCHED_PERF_EN
    logic [31:0]       io_perf_conflict;
    logic [31:0]       io_perf_forced;
`endif

    modport slave (
        input  io_r_req_valid, io_r_req_idx,
        input  io_w_req_valid, io_w_req_idx, io_w_req_mask, io_w_req_taken,
        input  arr_R0_data,
        output io_r_req_ready, io_r_resp_valid, io_r_resp_data,
        output io_w_req_ready, io_init_done,
        output arr_W0_en, arr_W0_addr, arr_W0_data, arr_W0_mask,
`ifdef CTR_ARRAY_SCHED_PERF_EN
        output io_perf_conflict, io_perf_forced,
`endif
        output arr_R0_en, arr_R0_addr
    );

    modport master (
        output io_r_req_valid, io_r_req_idx,
        output io_w_req_valid, io_w_req_idx, io_w_req_mask, io_w_req_taken,
        output arr_R0_data,
        input  io_r_req_ready, io_r_resp_valid, io_r_resp_data,
        input  io_w_req_ready, io_init_done,
        input  arr_W0_en, arr_W0_addr, arr_W0_data, arr_W0_mask,
`ifdef CTR_ARRAY_SCHED_PERF_EN
        input  io_perf_conflict, io_perf_forced,
`endif
        input  arr_R0_en, arr_R0_addr
    );
endinterface

// File: rtl/ctr_array_sched.sv
// rtl/ctr_array_sched.sv - read-port scheduler and saturating-counter RMW for a 512x16 array
// Optional perf counters enabled by defining CTR_ARRAY_SCHED_PERF_EN.
module ctr_array_sched #(
    parameter int               SETS       = 512,
    parameter int               IDX_W      = 9,
    parameter int               LANES      = 8,
    parameter int               CTR_W      = 2,
    parameter logic [CTR_W-1:0] CTR_INIT   = 2'b01,
    parameter int               STARVE_LIM = 4
) (
    input  logic              clock,
    input  logic              reset,
    ctr_array_sched_if.slave  bus
);
    localparam int DATA_W = LANES * CTR_W;
    localparam int ST_W   = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD_RD, S_UPD_WR} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  sweep_q;
    logic [IDX_W-1:0]  hold_idx_q;
    logic [LANES-1:0]  hold_mask_q;
    logic [LANES-1:0]  hold_taken_q;
    logic [ST_W-1:0]   starve_q;
    logic              init_done_q;
    logic              resp_valid_q;

    logic              in_rd;
    logic              force_rd;
    logic              upd_rd_go;
    logic              r_ready;
    logic              w_ready;
    logic              r_fire;
    logic              w_fire;
    logic [CTR_W-1:0]  lane_ctr;
    logic [DATA_W-1:0] wr_data;

    // Outputs are gated by reset so the port is quiet while reset is held.
    assign in_rd     = (state_q == S_UPD_RD) && !reset;
    assign force_rd  = in_rd && (starve_q == ST_W'(STARVE_LIM));
    assign upd_rd_go = in_rd && (force_rd || !bus.io_r_req_valid);
    assign r_ready   = !reset && (state_q != S_INIT) && !force_rd;
    assign w_ready   = !reset && (state_q == S_IDLE);
    assign r_fire    = r_ready && bus.io_r_req_valid;
    assign w_fire    = w_ready && bus.io_w_req_valid;

    always_comb begin
        wr_data  = '0;
        lane_ctr = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_ctr = bus.arr_R0_data[i*CTR_W +: CTR_W];
            if (hold_taken_q[i]) begin
                wr_data[i*CTR_W +: CTR_W] = (lane_ctr == '1) ? lane_ctr : lane_ctr + CTR_W'(1);
            end else begin
                wr_data[i*CTR_W +: CTR_W] = (lane_ctr == '0) ? lane_ctr : lane_ctr - CTR_W'(1);
            end
        end
    end

    always_comb begin
        bus.arr_W0_en   = 1'b0;
        bus.arr_W0_addr = sweep_q;
        bus.arr_W0_data = {LANES{CTR_INIT}};
        bus.arr_W0_mask = '1;
        if (!reset && state_q == S_INIT) begin
            bus.arr_W0_en = 1'b1;
        end else if (!reset && state_q == S_UPD_WR) begin
            bus.arr_W0_en   = 1'b1;
            bus.arr_W0_addr = hold_idx_q;
            bus.arr_W0_data = wr_data;
            bus.arr_W0_mask = hold_mask_q;
        end
    end

    always_comb begin
        bus.arr_R0_en   = 1'b0;
        bus.arr_R0_addr = bus.io_r_req_idx;
        if (upd_rd_go) begin
            bus.arr_R0_en   = 1'b1;
            bus.arr_R0_addr = hold_idx_q;
        end else if (r_fire) begin
            bus.arr_R0_en = 1'b1;
        end
    end

    assign bus.io_r_req_ready  = r_ready;
    assign bus.io_w_req_ready  = w_ready;
    assign bus.io_r_resp_valid = resp_valid_q;
    assign bus.io_r_resp_data  = bus.arr_R0_data;
    assign bus.io_init_done    = init_done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_INIT;
            sweep_q      <= '0;
            hold_idx_q   <= '0;
            hold_mask_q  <= '0;
            hold_taken_q <= '0;
            starve_q     <= '0;
            init_done_q  <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            resp_valid_q <= r_fire;
            case (state_q)
                S_INIT: begin
                    sweep_q <= sweep_q + IDX_W'(1);
                    if (sweep_q == IDX_W'(SETS - 1)) begin
                        state_q     <= S_IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_fire) begin
                        hold_idx_q   <= bus.io_w_req_idx;
                        hold_mask_q  <= bus.io_w_req_mask;
                        hold_taken_q <= bus.io_w_req_taken;
                        starve_q     <= '0;
                        state_q      <= S_UPD_RD;
                    end
                end
                S_UPD_RD: begin
                    // The starve count covers only the update currently waiting for the port.
                    if (upd_rd_go) begin
                        starve_q <= '0;
                        state_q  <= S_UPD_WR;
                    end else begin
                        starve_q <= starve_q + ST_W'(1);
                    end
                end
                S_UPD_WR: state_q <= S_IDLE;
                default:  state_q <= S_INIT;
            endcase
        end
    end

`ifdef CTR_ARRAY_SCHED_PERF_EN
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_forced_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_conflict_q <= '0;
            perf_forced_q   <= '0;
        end else begin
            if (in_rd && !upd_rd_go) perf_conflict_q <= perf_conflict_q + 32'd1;
            if (force_rd)            perf_forced_q   <= perf_forced_q + 32'd1;
        end
    end

    assign bus.io_perf_conflict = perf_conflict_q;
    assign bus.io_perf_forced   = perf_forced_q;
`endif
endmodule
